addsub_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit: the next generation of our 32-bit carry-lookahead add/sub. The operand is split into `WIDTH/GROUP` carry-lookahead groups, with one pipeline stage per group and the carry rippling stage to stage. A valid/ready handshake lets the ALU and multi-cycle datapath stall it. It produces result, carry-out, signed-overflow and zero flags, aligned with the result.

---
 rtl/addsub_pipe.sv | 142 ++++++++++++++
 tb/tb_addsub_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined carry-lookahead add/subtract, one pipeline stage per GROUP-bit group.
// Optional signed saturation is enabled by defining ADDSUB_PIPE_SAT_EN.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NG = WIDTH / GROUP;

  // Stage inputs (index 0 comes from the ports, index k from stage k-1)
  logic [WIDTH-1:0] ia  [NG];
  logic [WIDTH-1:0] ib  [NG];
  logic             ic  [NG];
  logic             iv  [NG];
  logic             iam [NG];
  // Stage results and registers
  logic [WIDTH-1:0] na  [NG];
  logic             nc  [NG];
  logic [WIDTH-1:0] qa  [NG];
  logic [WIDTH-1:0] qb  [NG];
  logic             qc  [NG];
  logic             qv  [NG];
  logic             qam [NG];
`ifdef ADDSUB_PIPE_SAT_EN
  logic             ist [NG];
  logic             qst [NG];
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif
  logic [GROUP-1:0] gs;
  logic             adv;

  function automatic logic [GROUP:0] cla(input logic [GROUP-1:0] x,
                                         input logic [GROUP-1:0] y,
                                         input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  assign adv      = !qv[NG-1] || out_ready;
  assign in_ready = adv;

  // The qa word carries finished sum groups below the active group and raw a above it.
  always_comb begin
    gs     = '0;
    ia[0]  = a;
    ib[0]  = b ^ {WIDTH{sub}};
    ic[0]  = sub;
    iv[0]  = in_valid;
    iam[0] = a[WIDTH-1];
`ifdef ADDSUB_PIPE_SAT_EN
    ist[0] = sat;
`endif
    for (int unsigned k = 1; k < NG; k++) begin
      ia[k]  = qa[k-1];
      ib[k]  = qb[k-1];
      ic[k]  = qc[k-1];
      iv[k]  = qv[k-1];
      iam[k] = qam[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
      ist[k] = qst[k-1];
`endif
    end
    for (int unsigned k = 0; k < NG; k++) begin
      {nc[k], gs} = cla(ia[k][GROUP*k +: GROUP], ib[k][GROUP*k +: GROUP], ic[k]);
      na[k]                   = ia[k];
      na[k][GROUP*k +: GROUP] = gs;
    end
  end

  // Data registers load only with a valid operation, so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NG; k++) begin
        qv[k]  <= 1'b0;
        qa[k]  <= '0;
        qb[k]  <= '0;
        qc[k]  <= 1'b0;
        qam[k] <= 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
        qst[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < NG; k++) begin
        qv[k] <= iv[k];
        if (iv[k]) begin
          qa[k]  <= na[k];
          qb[k]  <= ib[k];
          qc[k]  <= nc[k];
          qam[k] <= iam[k];
`ifdef ADDSUB_PIPE_SAT_EN
          qst[k] <= ist[k];
`endif
        end
      end
    end
  end

  always_comb begin
    out_valid = qv[NG-1];
    cout      = qc[NG-1];
    ovf       = (qam[NG-1] == qb[NG-1][WIDTH-1]) && (qa[NG-1][WIDTH-1] != qam[NG-1]);
`ifdef ADDSUB_PIPE_SAT_EN
    if (qst[NG-1] && ovf) begin
      r = qam[NG-1] ? SMIN : SMAX;
    end else begin
      r = qa[NG-1];
    end
`else
    r = qa[NG-1];
`endif
    zero = (r == '0);
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: 32/8, 16/4 and 8/8 instances, vector table plus
// stall and mid-flight reset sequences. Saturation vectors apply with ADDSUB_PIPE_SAT_EN.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv32 = 1'b0, iv16 = 1'b0, iv8 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
`ifdef ADDSUB_PIPE_SAT_EN
  logic        sat = 1'b0;
`endif
  logic        ir32, ov32, c32, o32, z32;
  logic [31:0] r32;
  logic        ir16, ov16, c16, o16, z16;
  logic [15:0] r16;
  logic        ir8, ov8, c8, o8, z8;
  logic [7:0]  r8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b), .sub(sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(ov32), .out_ready(out_ready), .r(r32), .cout(c32), .ovf(o32), .zero(z32));

  addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]), .sub(sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(ov16), .out_ready(out_ready), .r(r16), .cout(c16), .ovf(o16), .zero(z16));

  addsub_pipe #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]), .sub(sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(ov8), .out_ready(out_ready), .r(r8), .cout(c8), .ovf(o8), .zero(z8));

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        st;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
  } res_t;

  vec_t vecs[$];
  res_t exq[$];

  function automatic vec_t mk(input int w, input logic [31:0] a_, input logic [31:0] b_,
                              input logic s_, input logic st_, input logic [31:0] r_,
                              input logic c_, input logic o_, input logic z_);
    vec_t v;
    v.w = w; v.a = a_; v.b = b_; v.s = s_; v.st = st_;
    v.r = r_; v.c = c_; v.o = o_; v.z = z_;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic sample(input int w, output logic v, output logic [31:0] rr,
                        output logic cc, output logic oo, output logic zz);
    case (w)
      16:      begin v = ov16; rr = {16'h0, r16}; cc = c16; oo = o16; zz = z16; end
      8:       begin v = ov8;  rr = {24'h0, r8};  cc = c8;  oo = o8;  zz = z8;  end
      default: begin v = ov32; rr = r32;          cc = c32; oo = o32; zz = z32; end
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          n;
    logic        vo, cc, oo, zz;
    logic [31:0] rr;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.s; out_ready = 1'b1;
`ifdef ADDSUB_PIPE_SAT_EN
    sat = v.st;
`endif
    iv32 = (v.w == 32); iv16 = (v.w == 16); iv8 = (v.w == 8);
    @(negedge clk);
    iv32 = 1'b0; iv16 = 1'b0; iv8 = 1'b0;
    a = ~v.a; b = ~v.b; sub = ~v.s;
`ifdef ADDSUB_PIPE_SAT_EN
    sat = ~v.st;
`endif
    n = 1;
    sample(v.w, vo, rr, cc, oo, zz);
    while (!vo && n < 20) begin
      @(negedge clk);
      n++;
      sample(v.w, vo, rr, cc, oo, zz);
    end
    check($sformatf("v%0d latency", idx), n, (v.w == 8) ? 1 : 4);
    check($sformatf("v%0d r", idx), rr, v.r);
    check($sformatf("v%0d cout", idx), {31'h0, cc}, {31'h0, v.c});
    check($sformatf("v%0d ovf", idx), {31'h0, oo}, {31'h0, v.o});
    check($sformatf("v%0d zero", idx), {31'h0, zz}, {31'h0, v.z});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   issued, got, stalls, cyc, seen, n;
    logic [32:0] sum;
    logic [31:0] bx;
    res_t e;

    //      w   a             b             sub st  r             c  o  z
    vecs.push_back(mk(32, 32'h00FF_FFFF, 32'h0000_0001, 0, 0, 32'h0100_0000, 0, 0, 0));
    vecs.push_back(mk(32, 32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0));
    vecs.push_back(mk(32, 32'h0000_0005, 32'h0000_0005, 1, 0, 32'h0000_0000, 1, 0, 1));
    vecs.push_back(mk(32, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1));
    vecs.push_back(mk(32, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0));
    vecs.push_back(mk(32, 32'h0000_0003, 32'h0000_0005, 1, 0, 32'hFFFF_FFFE, 0, 0, 0));
    vecs.push_back(mk(32, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'hACF1_3568, 0, 0, 0));
    vecs.push_back(mk(32, 32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 0, 1));
    vecs.push_back(mk(32, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 1));
    vecs.push_back(mk(32, 32'h0000_0000, 32'h8000_0000, 1, 0, 32'h8000_0000, 0, 1, 0));
    vecs.push_back(mk(16, 32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 0));
    vecs.push_back(mk(16, 32'h0000_8000, 32'h0000_0001, 1, 0, 32'h0000_7FFF, 1, 1, 0));
    vecs.push_back(mk(16, 32'h0000_0005, 32'h0000_0005, 1, 0, 32'h0000_0000, 1, 0, 1));
    vecs.push_back(mk(16, 32'h0000_7FFF, 32'h0000_0001, 0, 0, 32'h0000_8000, 0, 1, 0));
    vecs.push_back(mk(8,  32'h0000_000F, 32'h0000_0001, 0, 0, 32'h0000_0010, 0, 0, 0));
    vecs.push_back(mk(8,  32'h0000_0080, 32'h0000_0001, 1, 0, 32'h0000_007F, 1, 1, 0));
    vecs.push_back(mk(8,  32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1));
    vecs.push_back(mk(8,  32'h0000_007F, 32'h0000_0001, 0, 0, 32'h0000_0080, 0, 1, 0));
`ifdef ADDSUB_PIPE_SAT_EN
    vecs.push_back(mk(32, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 0, 1, 0));
    vecs.push_back(mk(32, 32'h8000_0000, 32'h0000_0001, 1, 1, 32'h8000_0000, 1, 1, 0));
    vecs.push_back(mk(32, 32'h0000_0005, 32'h0000_0003, 1, 1, 32'h0000_0002, 1, 0, 0));
    vecs.push_back(mk(16, 32'h0000_7FFF, 32'h0000_0001, 0, 1, 32'h0000_7FFF, 0, 1, 0));
    vecs.push_back(mk(8,  32'h0000_007F, 32'h0000_0001, 0, 1, 32'h0000_007F, 0, 1, 0));
    vecs.push_back(mk(8,  32'h0000_0080, 32'h0000_0001, 1, 1, 32'h0000_0080, 1, 1, 0));
`endif

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst out_valid", {31'h0, ov32}, 32'h0);
    check("rst r", r32, 32'h0);
    check("rst cout", {31'h0, c32}, 32'h0);
    check("rst ovf", {31'h0, o32}, 32'h0);
    check("rst zero", {31'h0, z32}, 32'h1);
    check("rst in_ready", {31'h0, ir32}, 32'h1);
    check("rst zero16", {31'h0, z16}, 32'h1);
    check("rst in_ready8", {31'h0, ir8}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Back-to-back with a 3-cycle stall on the second result
    issued = 0; got = 0; stalls = 0; cyc = 0;
`ifdef ADDSUB_PIPE_SAT_EN
    sat = 1'b0;
`endif
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (issued < 6) begin
        a = 32'h1111_1111 * (issued + 1);
        b = 32'h0F0F_0F0F + issued;
        sub = issued[0];
        iv32 = 1'b1;
      end else begin
        iv32 = 1'b0;
      end
      out_ready = !(ov32 && got == 1 && stalls < 3);
      #1;
      if (!out_ready) begin
        stalls++;
        check("stall in_ready", {31'h0, ir32}, 32'h0);
        check("stall hold r", r32, exq[0].r);
      end
      if (iv32 && ir32) begin
        bx = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {32'h0, sub};
        e.r = sum[31:0];
        e.c = sum[32];
        e.o = (a[31] == bx[31]) && (sum[31] != a[31]);
        exq.push_back(e);
        issued++;
      end
      if (ov32 && out_ready) begin
        if (exq.size() == 0) begin
          check("b2b unexpected result", 32'h1, 32'h0);
        end else begin
          check($sformatf("b2b r%0d", got), r32, exq[0].r);
          check($sformatf("b2b cout%0d", got), {31'h0, c32}, {31'h0, exq[0].c});
          check($sformatf("b2b ovf%0d", got), {31'h0, o32}, {31'h0, exq[0].o});
          void'(exq.pop_front());
        end
        got++;
      end
    end
    iv32 = 1'b0;
    out_ready = 1'b1;
    check("b2b results", got, 6);
    check("b2b stall cycles", stalls, 3);
    check("b2b leftover", exq.size(), 0);

    // Reset with three operations in flight
    repeat (2) @(negedge clk);
    a = 32'h1; b = 32'h1; sub = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    a = 32'h2;
    @(negedge clk);
    a = 32'h3; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; iv32 = 1'b0;
    #1;
    check("midrst r", r32, 32'h0);
    check("midrst zero", {31'h0, z32}, 32'h1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    check("midrst no output", seen, 0);
    run_vec(99, mk(32, 32'h0000_0010, 32'h0000_0020, 0, 0, 32'h0000_0030, 0, 0, 0));

    n = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
